// File: rtl/dram_fill_cmd_gen.sv
// Fill-request walker: turns one (gaddr, len, bounds, bcast) request into
// ordered DRAM line-read addresses and per-segment copy/broadcast/pad commands.
`timescale 1ns/1ps
module dram_fill_cmd_gen #(
    parameter  int GBW    = 32,
    parameter  int LBW    = 16,
    parameter  int CSIZE  = 32,
    parameter  int VSIZE  = 32,
    localparam int CC_BW  = $clog2(CSIZE),
    localparam int CV_BW1 = $clog2(VSIZE + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 req_rdy,
    output logic                 req_ack,
    input  logic                 i_which,
    input  logic [GBW-1:0]       i_gaddr,
    input  logic [LBW:0]         i_len,
    input  logic [GBW-1:0]       i_bnd_lo,
    input  logic [GBW-1:0]       i_bnd_hi,
    input  logic                 i_bcast,
    output logic                 dramra_rdy,
    input  logic                 dramra_ack,
    output logic [GBW-CC_BW-1:0] o_dramra,
    output logic                 cmd_rdy,
    input  logic                 cmd_ack,
    output logic                 o_which,
    output logic [1:0]           o_cmd_type,
    output logic                 o_cmd_islast,
    output logic [CC_BW-1:0]     o_cmd_addrofs,
    output logic [CV_BW1-1:0]    o_cmd_len,
    output logic                 o_busy
);

    localparam int W1 = GBW + 1;

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_ADDR = 3'b010;
    localparam logic [2:0] S_CMD  = 3'b100;
    localparam int B_IDLE = 0;
    localparam int B_ADDR = 1;
    localparam int B_CMD  = 2;

    localparam logic [1:0] T_COPY  = 2'd0;
    localparam logic [1:0] T_BCAST = 2'd1;
    localparam logic [1:0] T_PAD   = 2'd2;

    localparam logic [W1-1:0] CSIZE_W = W1'(CSIZE);
    localparam logic [W1-1:0] VSIZE_W = W1'(VSIZE);

    function automatic logic [W1-1:0] min2(input logic [W1-1:0] x, input logic [W1-1:0] y);
        return (x < y) ? x : y;
    endfunction

    logic [2:0]     state_reg, state_next;
    logic [GBW-1:0] gaddr_reg, lo_reg, hi_reg;
    logic [LBW:0]   len_reg, pos_reg;
    logic           bcast_reg, which_reg, fetched_reg;

    logic [W1-1:0]          a_w, left_w, lo_w, hi_w, e_w, room_w, seg_n_w;
    logic [1:0]             seg_type;
    logic [CC_BW-1:0]       seg_ofs;
    logic                   seg_last;
    logic [GBW-CC_BW-1:0]   fetch_line;
    logic                   need_fetch;
    logic [LBW:0]           pos_sum;

    // All arithmetic is one bit wider than the address so hi/lo compares never wrap.
    always_comb begin
        a_w        = W1'(gaddr_reg) + W1'(pos_reg);
        left_w     = W1'(len_reg) - W1'(pos_reg);
        lo_w       = W1'(lo_reg);
        hi_w       = W1'(hi_reg);
        e_w        = W1'(gaddr_reg);
        room_w     = CSIZE_W - W1'(a_w[CC_BW-1:0]);
        seg_type   = T_PAD;
        seg_ofs    = '0;
        seg_n_w    = min2(left_w, VSIZE_W);
        seg_last   = 1'b0;
        fetch_line = a_w[GBW-1:CC_BW];
        if (bcast_reg) begin
            if (e_w >= lo_w && e_w < hi_w) begin
                seg_type   = T_BCAST;
                seg_ofs    = gaddr_reg[CC_BW-1:0];
                seg_last   = (seg_n_w == left_w);
                fetch_line = gaddr_reg[GBW-1:CC_BW];
            end
        end else if (a_w < lo_w) begin
            seg_n_w = min2(lo_w - a_w, seg_n_w);
        end else if (a_w < hi_w) begin
            seg_type = T_COPY;
            seg_ofs  = a_w[CC_BW-1:0];
            seg_n_w  = min2(min2(hi_w - a_w, room_w), min2(left_w, VSIZE_W));
            // A VSIZE split inside the same line keeps the line resident.
            seg_last = (seg_n_w == room_w) || (seg_n_w == hi_w - a_w) || (seg_n_w == left_w);
        end
        need_fetch = (seg_type != T_PAD) && !fetched_reg;
        pos_sum    = pos_reg + (LBW + 1)'(seg_n_w);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (req_rdy && i_len != '0) state_next = S_CMD;
            S_CMD: begin
                if (need_fetch)
                    state_next = S_ADDR;
                else if (cmd_ack && pos_sum == len_reg)
                    state_next = S_IDLE;
            end
            S_ADDR: if (dramra_ack) state_next = S_CMD;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg   <= S_IDLE;
            gaddr_reg   <= '0;
            lo_reg      <= '0;
            hi_reg      <= '0;
            len_reg     <= '0;
            pos_reg     <= '0;
            bcast_reg   <= 1'b0;
            which_reg   <= 1'b0;
            fetched_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (req_ack) begin
                gaddr_reg   <= i_gaddr;
                lo_reg      <= i_bnd_lo;
                hi_reg      <= i_bnd_hi;
                len_reg     <= i_len;
                bcast_reg   <= i_bcast;
                which_reg   <= i_which;
                pos_reg     <= '0;
                fetched_reg <= 1'b0;
            end
            if (cmd_rdy && cmd_ack) begin
                pos_reg <= pos_sum;
                if (seg_last)
                    fetched_reg <= 1'b0;
            end
            if (dramra_rdy && dramra_ack)
                fetched_reg <= 1'b1;
        end
    end

    assign req_ack       = state_reg[B_IDLE] && req_rdy;
    assign dramra_rdy    = state_reg[B_ADDR];
    assign cmd_rdy       = state_reg[B_CMD] && !need_fetch;
    assign o_busy        = !state_reg[B_IDLE];
    assign o_which       = which_reg;
    assign o_dramra      = dramra_rdy ? fetch_line : '0;
    assign o_cmd_type    = cmd_rdy ? seg_type : '0;
    assign o_cmd_islast  = cmd_rdy && seg_last;
    assign o_cmd_addrofs = cmd_rdy ? seg_ofs : '0;
    assign o_cmd_len     = cmd_rdy ? seg_n_w[CV_BW1-1:0] : '0;

endmodule
